step_sequencer: RTL

//  Pattern-driven trigger scheduler for the drum voices. Holds a NUM_VOICES x NUM_STEPS
//  hit pattern and advances one step every TICKS_PER_STEP clocks while running.

---
 rtl/step_sequencer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/step_sequencer.sv
// Step sequencer: holds a per-voice hit pattern, steps through it at a fixed
// tick rate while running, and drives each sample player's enable. Each hit
// drops the enable for one cycle and then holds it high for GATE_LEN cycles.
module step_sequencer #(
  parameter int NUM_VOICES     = 4,
  parameter int NUM_STEPS      = 16,
  parameter int TICKS_PER_STEP = 12500,
  parameter int GATE_LEN       = 4000,
  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1,
  localparam int SW = $clog2(NUM_STEPS),
  localparam int TW = $clog2(TICKS_PER_STEP)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pat_we,
  input  logic [VW-1:0]         pat_voice,
  input  logic [SW-1:0]         pat_step,
  input  logic                  pat_val,
  input  logic [NUM_VOICES-1:0] mute,
  output logic [NUM_VOICES-1:0] voice_en,
  output logic [SW-1:0]         step_idx,
  output logic                  step_tick,
  output logic                  running
);

  localparam logic [TW-1:0] TICK_MAX  = TW'(TICKS_PER_STEP - 1);
  localparam logic [15:0]   GATE_INIT = 16'(GATE_LEN);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  state_e                  state_q, state_d;
  logic [TW-1:0]           tick_cnt_q, tick_cnt_d;
  logic [SW-1:0]           step_idx_q, step_idx_d;
  logic [NUM_VOICES-1:0]   voice_en_q, voice_en_d;
  logic [15:0]             gate_cnt_q [NUM_VOICES];
  logic [15:0]             gate_cnt_d [NUM_VOICES];
  logic [NUM_STEPS-1:0]    pattern_q  [NUM_VOICES];
  logic [NUM_STEPS-1:0]    pattern_d  [NUM_VOICES];
  logic                    fire;
  logic [NUM_VOICES-1:0]   hit;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, independent of order.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: stop always wins over start; start is ignored while running.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first, otherwise an unassigned path infers a latch.
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start && !stop) state_d = ST_RUN;
      ST_RUN:  if (stop)           state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: a step fires on the first tick of every step while running.
  always_comb begin
    running   = (state_q == ST_RUN);
    fire      = (state_q == ST_RUN) && (tick_cnt_q == '0);
    step_tick = fire;
  end

  // ---------------------------------------------------------------------------
  // Step timing
  // ---------------------------------------------------------------------------

  // Tick and step counters; cleared on stop and on entry to RUN, frozen in IDLE.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    step_idx_d = step_idx_q;
    if (stop) begin
      tick_cnt_d = '0;
      step_idx_d = '0;
    end else if (state_q == ST_IDLE) begin
      if (start) begin
        tick_cnt_d = '0;
        step_idx_d = '0;
      end
    end else if (tick_cnt_q == TICK_MAX) begin
      tick_cnt_d = '0;
      // NUM_STEPS is a power of two, so the step index wraps by overflow.
      step_idx_d = step_idx_q + SW'(1);
    end else begin
      tick_cnt_d = tick_cnt_q + TW'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
      step_idx_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      step_idx_q <= step_idx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pattern store
  // ---------------------------------------------------------------------------

  // Pattern write; hits read the registered pattern, so a write landing in a
  // fire cycle only shows up on the next pass over that step.
  always_comb begin
    pattern_d = pattern_q;
    if (pat_we && (int'(pat_voice) < NUM_VOICES)) begin
      pattern_d[pat_voice][pat_step] = pat_val;
    end
  end

  // Pattern register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the pattern array is deliberately reset so playback after reset
    // is silent; without that requirement a storage array would be left
    // unreset to keep it mappable to RAM.
    if (rst) pattern_q <= '{default: '0};
    else     pattern_q <= pattern_d;
  end

  // ---------------------------------------------------------------------------
  // Voice gates
  // ---------------------------------------------------------------------------

  // Per-voice gate: stop and mute silence, a hit opens a one-cycle gap and
  // reloads the gate, otherwise a running gate counts down with enable high.
  always_comb begin
    voice_en_d = '0;
    gate_cnt_d = gate_cnt_q;
    for (int v = 0; v < NUM_VOICES; v++) begin
      hit[v] = fire && pattern_q[v][step_idx_q] && !mute[v];
      if (stop || mute[v]) begin
        voice_en_d[v] = 1'b0;
        gate_cnt_d[v] = '0;
      end else if (hit[v]) begin
        voice_en_d[v] = 1'b0;
        gate_cnt_d[v] = GATE_INIT;
      end else if (gate_cnt_q[v] != '0) begin
        voice_en_d[v] = 1'b1;
        gate_cnt_d[v] = gate_cnt_q[v] - 16'd1;
      end
    end
  end

  // Gate registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      voice_en_q <= '0;
      gate_cnt_q <= '{default: '0};
    end else begin
      voice_en_q <= voice_en_d;
      gate_cnt_q <= gate_cnt_d;
    end
  end

  assign voice_en = voice_en_q;
  assign step_idx = step_idx_q;

endmodule
